// File: rtl/gate_bist_controller.sv
// LFSR pattern generator + MISR response compactor driving one combinational gate model.
// Optional registered golden-signature compare is enabled by defining GATE_BIST_GOLDEN_CMP_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs cleared
// RUN   | one pattern issued per cycle, LFSR stepping
// FLUSH | draining the capture-delay valid pipe
// DONE  | signature and pattern frozen, done high
module gate_bist_controller #(
  parameter int                IN_W       = 19,
  parameter int                OUT_W      = 10,
  parameter int                PAT_CNT    = 1024,
  parameter logic [IN_W-1:0]   LFSR_SEED  = 19'h00001,
  parameter logic [IN_W-1:0]   LFSR_TAPS  = 19'h40013,
  parameter logic [OUT_W-1:0]  MISR_TAPS  = 10'h204,
  parameter int                CAP_DLY    = 0
`ifdef GATE_BIST_GOLDEN_CMP_EN
  ,
  parameter logic [OUT_W-1:0]  GOLDEN_SIG = 10'h000
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [IN_W-1:0]  o_pat_out,
  input  logic [OUT_W-1:0] i_resp_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [OUT_W-1:0] o_signature
`ifdef GATE_BIST_GOLDEN_CMP_EN
  ,
  output logic             o_pass
`endif
);

  localparam int CNT_W = (PAT_CNT > 1) ? $clog2(PAT_CNT) : 1;
  localparam int PW    = (CAP_DLY > 0) ? CAP_DLY : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_CNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [IN_W-1:0]  r_pat;
  logic [OUT_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_vpipe;

  logic [1:0]       w_state_nxt;
  logic [IN_W-1:0]  w_pat_step;
  logic [OUT_W-1:0] w_sig_upd;
  logic [OUT_W-1:0] w_sig_nxt;
  logic [PW-1:0]    w_vpipe_nxt;
  logic             w_issue;
  logic             w_last;
  logic             w_tail;
  logic             w_start_run;

  always_comb begin
    w_issue     = (r_state == S_RUN);
    w_last      = w_issue && (r_cnt == CNT_LAST);
    w_start_run = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_pat_step  = {r_pat[IN_W-2:0], ^(r_pat & LFSR_TAPS)};
    w_sig_upd   = {r_sig[OUT_W-2:0], ^(r_sig & MISR_TAPS)} ^ i_resp_in;

    // With no capture delay the response belongs to the pattern issued this cycle.
    if (CAP_DLY == 0) begin
      w_vpipe_nxt = '0;
      w_tail      = w_issue;
    end else begin
      w_vpipe_nxt = (r_vpipe << 1) | PW'(w_issue);
      w_tail      = r_vpipe[PW-1];
    end

    if (w_start_run)  w_sig_nxt = '0;
    else if (w_tail)  w_sig_nxt = w_sig_upd;
    else              w_sig_nxt = r_sig;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_run) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = (CAP_DLY == 0) ? S_DONE : S_FLUSH;
      S_FLUSH: if (w_vpipe_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (w_start_run) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_vpipe <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vpipe <= w_vpipe_nxt;
      r_sig   <= w_sig_nxt;
      if (w_start_run) begin
        r_pat <= LFSR_SEED;
        r_cnt <= '0;
      end else if (w_issue && !w_last) begin
        r_pat <= w_pat_step;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef GATE_BIST_GOLDEN_CMP_EN
  logic r_pass;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pass <= 1'b0;
    else       r_pass <= (w_state_nxt == S_DONE) && (w_sig_nxt == GOLDEN_SIG);
  end

  assign o_pass = r_pass;
`endif

  assign o_pat_out   = r_pat;
  assign o_signature = r_sig;
  assign o_busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign o_done      = (r_state == S_DONE);

endmodule
